nibble_packer: RTL

- Upstream feeder for the NibbleSwapper stage. Collects a 4-bit nibble stream (valid/ready) into bytes and presents each byte on data_out with a per-byte swap_en, ready for direct connection to the swapper's data_in/swap_en.
- Handles back-pressure with a one-byte output register.
- A dangling half-byte is padded and emitted on timeout or explicit flush.

---
 rtl/nibble_pkg.sv | 14 +
 rtl/nibble_timeout_ctr.sv | 27 ++
 rtl/nibble_packer.sv | 97 +++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble packer and its timeout counter.
package nibble_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  localparam logic [NIB_W-1:0] PAD_DEFAULT = 4'h0;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

endpackage

// File: rtl/nibble_timeout_ctr.sv
// Saturating idle counter; expired is high once the count sits at TIMEOUT-1.
module nibble_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/nibble_packer.sv
// Packs a valid/ready nibble stream into bytes with a one-byte output register;
// a dangling half-byte is padded out on timeout or flush.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int                 TIMEOUT    = 16,
  parameter logic [NIB_W-1:0]   PAD_NIBBLE = PAD_DEFAULT,
  parameter bit                 FIRST_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIB_W-1:0]  nib_in,
  input  logic              nib_valid,
  output logic              nib_ready,
  input  logic              swap_req,
  input  logic              flush,
  output logic [BYTE_W-1:0] data_out,
  output logic              swap_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              partial
);

  // Handshake: a nibble transfers on any rising edge where nib_valid && nib_ready;
  // a byte transfers on any rising edge where out_valid && out_ready.

  state_t           state;
  logic [NIB_W-1:0] held_nib;
  logic             held_swap;
  logic             flush_pend;
  logic             slot_free;
  logic             hs;
  logic             expired;
  logic             force_req;

  assign slot_free = !out_valid || out_ready;
  assign nib_ready = !rst && ((state == EMPTY) || slot_free);
  assign hs        = nib_valid && nib_ready;
  assign force_req = (state == HALF) && (expired || flush || flush_pend);

  nibble_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == EMPTY) && hs),
    .enable  ((state == HALF) && !hs),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      held_nib   <= '0;
      held_swap  <= 1'b0;
      flush_pend <= 1'b0;
      data_out   <= '0;
      swap_en    <= 1'b0;
      partial    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        EMPTY: begin
          if (hs) begin
            held_nib   <= nib_in;
            held_swap  <= swap_req;
            flush_pend <= 1'b0;
            state      <= HALF;
          end
        end
        HALF: begin
          if (hs) begin
            data_out   <= FIRST_HIGH ? {held_nib, nib_in} : {nib_in, held_nib};
            swap_en    <= held_swap;
            partial    <= 1'b0;
            out_valid  <= 1'b1;
            flush_pend <= 1'b0;
            state      <= EMPTY;
          end else if (force_req && slot_free) begin
            data_out   <= FIRST_HIGH ? {held_nib, PAD_NIBBLE} : {PAD_NIBBLE, held_nib};
            swap_en    <= held_swap;
            partial    <= 1'b1;
            out_valid  <= 1'b1;
            flush_pend <= 1'b0;
            state      <= EMPTY;
          end else if (flush) begin
            // Output slot busy: remember the flush until the byte can go out.
            flush_pend <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
